fsm_pkt_checker_param: RTL and testbench

// - Parametrised packet-stream checker FSM: validates each bus word's header field and

---
 rtl/fsm_pkt_checker_param_pkg.sv | 18 +
 rtl/fsm_pkt_checker_param_sat_counter.sv | 19 +
 rtl/fsm_pkt_checker_param.sv | 105 ++++++++++
 tb/tb_fsm_pkt_checker_param.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fsm_pkt_checker_param_pkg.sv
// Shared definitions for the packet-stream checker: one-hot state encoding and state width.
package fsm_pkt_checker_param_pkg;

  localparam int STATE_WIDTH = 5;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE      = 5'b00001,
    FIRST_PKT = 5'b00010,
    REG_PKT   = 5'b00100,
    F_ERR     = 5'b01000,
    SEQ_ERR   = 5'b10000
  } state_t;

  function automatic logic is_err_state(input state_t s);
    return (s == F_ERR) || (s == SEQ_ERR);
  endfunction

endpackage

// File: rtl/fsm_pkt_checker_param_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/fsm_pkt_checker_param.sv
// Packet-stream checker: validates header and rolling sequence number of each valid word,
// forwards good words with one clock of latency, and counts good words and errors.
module fsm_pkt_checker_param
  import fsm_pkt_checker_param_pkg::*;
#(
  parameter int                   BUS_WIDTH   = 16,
  parameter int                   HDR_WIDTH   = 4,
  parameter logic [HDR_WIDTH-1:0] HDR_PATTERN = 4'hF,
  parameter int                   SEQ_WIDTH   = 4,
  parameter int                   SEQ_LSB     = 8,
  parameter bit                   STICKY_ERR  = 1'b0,
  parameter int                   CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUS_WIDTH-1:0]   data_in,
  input  logic                   data_valid,
  output logic [BUS_WIDTH-1:0]   data_out,
  output logic                   data_out_valid,
  output logic [STATE_WIDTH-1:0] state,
  output logic [STATE_WIDTH-1:0] nxt_state,
  output logic                   error,
  output logic                   nxt_error,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   err_count
);

  state_t               state_q;
  state_t               state_d;
  logic [SEQ_WIDTH-1:0] seq_ref;
  logic [SEQ_WIDTH-1:0] seq_expect;
  logic [SEQ_WIDTH-1:0] seq_field;
  logic                 hdr_ok;
  logic                 seq_ok;
  logic                 good_word;
  logic                 bad_word;

  assign seq_field  = data_in[SEQ_LSB +: SEQ_WIDTH];
  assign seq_expect = seq_ref + SEQ_WIDTH'(1);
  assign hdr_ok     = (data_in[BUS_WIDTH-1 -: HDR_WIDTH] == HDR_PATTERN);
  assign seq_ok     = (seq_field == seq_expect);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    good_word = 1'b0;
    bad_word  = 1'b0;
    if (reset) begin
      state_d = IDLE;
    end else if (data_valid) begin
      unique case (state_q)
        IDLE:
          state_d = hdr_ok ? FIRST_PKT : F_ERR;
        FIRST_PKT, REG_PKT:
          if (!hdr_ok)      state_d = F_ERR;
          else if (!seq_ok) state_d = SEQ_ERR;
          else              state_d = REG_PKT;
        F_ERR, SEQ_ERR:
          if (STICKY_ERR)   state_d = state_q;
          else              state_d = hdr_ok ? FIRST_PKT : F_ERR;
        default:
          state_d = IDLE;
      endcase
      good_word = (state_d == FIRST_PKT) || (state_d == REG_PKT);
      bad_word  = is_err_state(state_d);
    end
  end

  assign nxt_state = state_d;
  assign nxt_error = is_err_state(state_d);
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      error          <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      seq_ref        <= '0;
    end else begin
      state_q        <= state_d;
      error          <= nxt_error;
      data_out_valid <= good_word;
      if (good_word) begin
        data_out <= data_in;
        seq_ref  <= seq_field;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (good_word),
    .count (pkt_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bad_word),
    .count (err_count)
  );

endmodule

// File: tb/tb_fsm_pkt_checker_param.sv
// Directed bench: a resyncing checker and a sticky-error checker share one input stream.
module tb_fsm_pkt_checker_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;

  logic [15:0] a_dout, b_dout;
  logic        a_dov, b_dov, a_err, b_err, a_nerr, b_nerr;
  logic [4:0]  a_st, b_st, a_nst, b_nst;
  logic [7:0]  a_pkt, b_pkt, a_ecnt, b_ecnt;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] S_IDLE = 5'b00001, S_FIRST = 5'b00010, S_REG = 5'b00100,
                         S_FERR = 5'b01000, S_SERR = 5'b10000;

  always #5 clk = ~clk;

  fsm_pkt_checker_param #(.STICKY_ERR(1'b0)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_out(a_dout), .data_out_valid(a_dov), .state(a_st), .nxt_state(a_nst),
    .error(a_err), .nxt_error(a_nerr), .pkt_count(a_pkt), .err_count(a_ecnt)
  );

  fsm_pkt_checker_param #(.STICKY_ERR(1'b1)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_out(b_dout), .data_out_valid(b_dov), .state(b_st), .nxt_state(b_nst),
    .error(b_err), .nxt_error(b_nerr), .pkt_count(b_pkt), .err_count(b_ecnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one word for one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic [15:0] d, input logic v);
    data_in    = d;
    data_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [4:0] st, input logic [15:0] dout,
                         input logic dov, input logic err, input logic [7:0] pkt,
                         input logic [7:0] ecnt);
    check({tag, ".a_state"}, a_st, st);
    check({tag, ".a_dout"},  a_dout, dout);
    check({tag, ".a_dov"},   a_dov, dov);
    check({tag, ".a_error"}, a_err, err);
    check({tag, ".a_pkt"},   a_pkt, pkt);
    check({tag, ".a_ecnt"},  a_ecnt, ecnt);
  endtask

  initial begin
    reset = 1'b1; data_in = 16'hF0AA; data_valid = 1'b1;
    #1;
    check("rst_nxt_state", a_nst, S_IDLE);
    check("rst_nxt_error", a_nerr, 1'b0);
    @(posedge clk); #1;
    cyc(16'hF0AA, 1'b1);
    check_a("reset", S_IDLE, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);

    // Basic accept stream; the word in the reset cycle was dropped.
    reset = 1'b0;
    data_in = 16'hF0AA; data_valid = 1'b1; #1;
    check("idle_nxt_state", a_nst, S_FIRST);
    @(posedge clk); #1;
    check_a("w0", S_FIRST, 16'hF0AA, 1'b1, 1'b0, 8'd1, 8'd0);
    cyc(16'hF1BB, 1'b1);
    check_a("w1", S_REG, 16'hF1BB, 1'b1, 1'b0, 8'd2, 8'd0);
    cyc(16'hF2CC, 1'b1);
    check_a("w2", S_REG, 16'hF2CC, 1'b1, 1'b0, 8'd3, 8'd0);

    // Walk the sequence up to D, then across the F -> 0 wrap.
    for (int s = 3; s <= 13; s++) cyc({4'hF, 4'(s), 8'h00}, 1'b1);
    check_a("seq_d", S_REG, 16'hFD00, 1'b1, 1'b0, 8'd14, 8'd0);
    cyc(16'hFE00, 1'b1);
    cyc(16'hFF00, 1'b1);
    cyc(16'hF000, 1'b1);
    check_a("wrap", S_REG, 16'hF000, 1'b1, 1'b0, 8'd17, 8'd0);

    // Sequence gap.
    cyc(16'hF100, 1'b1);
    data_in = 16'hF300; #1;
    check("gap_nxt_state", a_nst, S_SERR);
    check("gap_nxt_error", a_nerr, 1'b1);
    @(posedge clk); #1;
    check_a("seq_err", S_SERR, 16'hF100, 1'b0, 1'b1, 8'd18, 8'd1);
    check("seq_err.b_state", b_st, S_SERR);

    // Good header resyncs the non-sticky checker; the sticky one holds.
    cyc(16'hF500, 1'b1);
    check_a("resync", S_FIRST, 16'hF500, 1'b1, 1'b0, 8'd19, 8'd1);
    check("sticky_hold.b_state", b_st, S_SERR);
    check("sticky_hold.b_ecnt", b_ecnt, 8'd2);
    check("sticky_hold.b_dout", b_dout, 16'hF100);
    check("sticky_hold.b_pkt", b_pkt, 8'd18);
    check("sticky_hold.b_dov", b_dov, 1'b0);
    cyc(16'hF600, 1'b1);
    check_a("after_resync", S_REG, 16'hF600, 1'b1, 1'b0, 8'd20, 8'd1);

    // Header error from REG_PKT; header error wins even with a good sequence.
    cyc(16'hE700, 1'b1);
    check_a("hdr_err", S_FERR, 16'hF600, 1'b0, 1'b1, 8'd20, 8'd2);
    check("hdr_err.b_ecnt", b_ecnt, 8'd4);
    cyc(16'hF300, 1'b1);
    check_a("hdr_resync", S_FIRST, 16'hF300, 1'b1, 1'b0, 8'd21, 8'd2);
    cyc(16'hF400, 1'b1);
    check_a("pre_idle", S_REG, 16'hF400, 1'b1, 1'b0, 8'd22, 8'd2);

    // Idle bus: garbage on data_in must be ignored.
    for (int i = 0; i < 5; i++) begin
      data_in = 16'h0B00; data_valid = 1'b0; #1;
      check("idle_nxt_state", a_nst, S_REG);
      @(posedge clk); #1;
      check_a("idle_hold", S_REG, 16'hF400, 1'b0, 1'b0, 8'd22, 8'd2);
    end

    // Reset during REG_PKT.
    reset = 1'b1;
    cyc(16'hF500, 1'b1);
    check_a("mid_reset", S_IDLE, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    reset = 1'b0;

    // Header error straight from IDLE; sticky F_ERR holds on a good header.
    cyc(16'hE200, 1'b1);
    check_a("idle_hdr_err", S_FERR, 16'h0000, 1'b0, 1'b1, 8'd0, 8'd1);
    cyc(16'hF300, 1'b1);
    check_a("ferr_resync", S_FIRST, 16'hF300, 1'b1, 1'b0, 8'd1, 8'd1);
    check("sticky_ferr.b_state", b_st, S_FERR);
    check("sticky_ferr.b_ecnt", b_ecnt, 8'd2);
    check("sticky_ferr.b_error", b_err, 1'b1);

    // Error counter saturation.
    for (int i = 0; i < 253; i++) cyc(16'hE000, 1'b1);
    check("sat_254.a_ecnt", a_ecnt, 8'd254);
    cyc(16'hE000, 1'b1);
    check("sat_255.a_ecnt", a_ecnt, 8'hFF);
    for (int i = 0; i < 46; i++) cyc(16'hE000, 1'b1);
    check_a("sat_hold", S_FERR, 16'hF300, 1'b0, 1'b1, 8'd1, 8'hFF);
    check("sat_hold.b_ecnt", b_ecnt, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
